// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file writeback slice.
//   NUM_REGS : architectural registers / scoreboard depth
//   ADDR_W   : register address width (clog2(NUM_REGS))
//   DATA_W   : writeback data width
// Types: rf_addr_t, rf_data_t, wb_req_t {valid, addr, data}.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    typedef struct packed {
        logic     valid;
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

    // x0 is architecturally zero: writes to it are consumed but never committed.
    function automatic logic is_x0(input rf_addr_t addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write bit per architectural register, used by issue for RAW stalls.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   set_en_i, set_addr_i  : issue marks a destination pending
//   clr_en_i, clr_addr_i  : writeback acceptance clears a destination
//   chk_addr1/2_i         : source operands to check
//   chk_busy1/2_o         : combinational pending lookups (no same-cycle bypass)
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en_i,
    input  rf_addr_t set_addr_i,
    input  logic     clr_en_i,
    input  rf_addr_t clr_addr_i,
    input  rf_addr_t chk_addr1_i,
    input  rf_addr_t chk_addr2_i,
    output logic     chk_busy1_o,
    output logic     chk_busy2_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // pending[0] is tied low; x0 never has an outstanding producer.
    assign pending_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en_i && (set_addr_i == rf_addr_t'(gi));
            assign clr_hit = clr_en_i && (clr_addr_i == rf_addr_t'(gi));
            // A same-cycle set means a newer producer was issued, so it
            // must survive the retirement of the older one.
            assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign chk_busy1_o = pending_q[chk_addr1_i];
    assign chk_busy2_o = pending_q[chk_addr2_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the load unit (req0)
// and the ALU (req1), and tracks in-flight producers in a scoreboard.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req0_valid/ready/addr/data        : load-unit writeback handshake
//   req1_valid/ready/addr/data        : ALU writeback handshake
//   rf_write_en/addr/data             : registered register-file write port
//   sb_set_en, sb_set_addr            : issue marks a destination pending
//   chk_addr1/2, chk_busy1/2          : RAW hazard lookups
// Build option: RF_WB_RR_EN selects round-robin arbitration; when undefined
// req0 has fixed priority and req1 may starve.
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     req0_valid,
    output logic     req0_ready,
    input  rf_addr_t req0_addr,
    input  rf_data_t req0_data,
    input  logic     req1_valid,
    output logic     req1_ready,
    input  rf_addr_t req1_addr,
    input  rf_data_t req1_data,
    output logic     rf_write_en,
    output rf_addr_t rf_write_addr,
    output rf_data_t rf_write_data,
    input  logic     sb_set_en,
    input  rf_addr_t sb_set_addr,
    input  rf_addr_t chk_addr1,
    input  rf_addr_t chk_addr2,
    output logic     chk_busy1,
    output logic     chk_busy2
);

    wb_req_t  req0_s;
    wb_req_t  req1_s;
    wb_req_t  sel_s;
    logic     accept;

    logic     wr_en_q;
    rf_addr_t wr_addr_q;
    rf_data_t wr_data_q;

    assign req0_s = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign req1_s = '{valid: req1_valid, addr: req1_addr, data: req1_data};

`ifdef RF_WB_RR_EN
    // last_grant_q = 1 means req1 was granted most recently, so req0 wins
    // the next conflict. Reset value makes req0 win the first one.
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= req1_ready;
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = req0_s.valid && (!req1_s.valid ||  last_grant_q);
            req1_ready = req1_s.valid && (!req0_s.valid || !last_grant_q);
        end
    end
`else
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = req0_s.valid;
            req1_ready = req1_s.valid && !req0_s.valid;
        end
    end
`endif

    assign accept = req0_ready || req1_ready;
    assign sel_s  = req0_ready ? req0_s : req1_s;

    // Write-port register: one accepted request per cycle appears here in the
    // following cycle. x0 writes update addr/data but never raise the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (accept) begin
            wr_en_q   <= !is_x0(sel_s.addr);
            wr_addr_q <= sel_s.addr;
            wr_data_q <= sel_s.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign rf_write_en   = wr_en_q;
    assign rf_write_addr = wr_addr_q;
    assign rf_write_data = wr_data_q;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (sb_set_en),
        .set_addr_i  (sb_set_addr),
        .clr_en_i    (accept),
        .clr_addr_i  (sel_s.addr),
        .chk_addr1_i (chk_addr1),
        .chk_addr2_i (chk_addr2),
        .chk_busy1_o (chk_busy1),
        .chk_busy2_o (chk_busy2)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter. Inputs change 1 ns after a rising edge;
// combinational outputs are sampled 1 ns later and registered outputs 1 ns
// after the next rising edge. Expectations adapt to RF_WB_RR_EN.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     req0_valid, req1_valid;
    logic     req0_ready, req1_ready;
    rf_addr_t req0_addr, req1_addr;
    rf_data_t req0_data, req1_data;
    logic     rf_write_en;
    rf_addr_t rf_write_addr;
    rf_data_t rf_write_data;
    logic     sb_set_en;
    rf_addr_t sb_set_addr, chk_addr1, chk_addr2;
    logic     chk_busy1, chk_busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .sb_set_en     (sb_set_en),
        .sb_set_addr   (sb_set_addr),
        .chk_addr1     (chk_addr1),
        .chk_addr2     (chk_addr2),
        .chk_busy1     (chk_busy1),
        .chk_busy2     (chk_busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input rf_addr_t a, input rf_data_t d);
        req0_valid = v; req0_addr = a; req0_data = d;
    endtask

    task automatic drive1(input logic v, input rf_addr_t a, input rf_data_t d);
        req1_valid = v; req1_addr = a; req1_data = d;
    endtask

    task automatic check_wr(input string tag, input logic en, input rf_addr_t a, input rf_data_t d);
        check({tag, ".en"},   64'(rf_write_en),   64'(en));
        check({tag, ".addr"}, 64'(rf_write_addr), 64'(a));
        check({tag, ".data"}, 64'(rf_write_data), 64'(d));
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, ".r0"}, 64'(req0_ready), 64'(r0));
        check({tag, ".r1"}, 64'(req1_ready), 64'(r1));
    endtask

    initial begin
        reset = 1'b1;
        drive0(1'b1, 5'd1, 32'h1);   // valid during reset must not be accepted
        drive1(1'b0, '0, '0);
        sb_set_en = 1'b0; sb_set_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
        tick();
        tick();
        settle();
        check_rdy("reset_ready", 1'b0, 1'b0);
        check_wr("reset_wr", 1'b0, 5'd0, 32'h0);
        chk_addr1 = 5'd1; settle();
        check("reset_busy", 64'(chk_busy1), 64'd0);

        // ---- Single ALU write ------------------------------------------
        drive0(1'b0, '0, '0);
        tick();
        reset = 1'b0;
        drive1(1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        check_rdy("alu_single", 1'b0, 1'b1);
        tick();
        drive1(1'b0, '0, '0);
        check_wr("alu_single_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("alu_single_idle.en", 64'(rf_write_en), 64'd0);

        // ---- Simultaneous requests -------------------------------------
        drive0(1'b1, 5'd3, 32'h33);
        drive1(1'b1, 5'd4, 32'h44);
        settle();
        check_rdy("both_c1", 1'b1, 1'b0);
        tick();
        settle();
        check_wr("both_c1_wr", 1'b1, 5'd3, 32'h33);
`ifdef RF_WB_RR_EN
        check_rdy("both_c2", 1'b0, 1'b1);
        tick();
        check_wr("both_c2_wr", 1'b1, 5'd4, 32'h44);
        settle();
        check_rdy("both_c3", 1'b1, 1'b0);
`else
        check_rdy("both_c2", 1'b1, 1'b0);
        tick();
        check_wr("both_c2_wr", 1'b1, 5'd3, 32'h33);
        settle();
        check_rdy("both_c3", 1'b1, 1'b0);
`endif
        tick();
        drive0(1'b0, '0, '0);
        check_wr("both_c3_wr", 1'b1, 5'd3, 32'h33);
        settle();
        check_rdy("alone_r1", 1'b0, 1'b1);
        tick();
        drive1(1'b0, '0, '0);
        check_wr("alone_r1_wr", 1'b1, 5'd4, 32'h44);

        // ---- Scoreboard lifecycle --------------------------------------
        sb_set_en = 1'b1; sb_set_addr = 5'd7; chk_addr1 = 5'd7;
        settle();
        check("sb_no_bypass", 64'(chk_busy1), 64'd0);
        tick();
        sb_set_en = 1'b0;
        check("sb_set_busy", 64'(chk_busy1), 64'd1);
        tick();
        check("sb_hold_busy", 64'(chk_busy1), 64'd1);
        drive0(1'b1, 5'd7, 32'h77);
        settle();
        check("sb_busy_before_accept", 64'(chk_busy1), 64'd1);
        check_rdy("sb_wr", 1'b1, 1'b0);
        tick();
        drive0(1'b0, '0, '0);
        check("sb_cleared", 64'(chk_busy1), 64'd0);
        check_wr("sb_wr_port", 1'b1, 5'd7, 32'h77);

        // ---- Set/clear collision ---------------------------------------
        sb_set_en = 1'b1; sb_set_addr = 5'd9; chk_addr2 = 5'd9;
        tick();
        check("coll_pre", 64'(chk_busy2), 64'd1);
        drive1(1'b1, 5'd9, 32'h99);    // set still asserted on 9
        settle();
        check_rdy("coll", 1'b0, 1'b1);
        tick();
        sb_set_en = 1'b0;
        drive1(1'b0, '0, '0);
        check("coll_set_wins", 64'(chk_busy2), 64'd1);
        check_wr("coll_wr", 1'b1, 5'd9, 32'h99);
        drive1(1'b1, 5'd9, 32'h9A);
        tick();
        drive1(1'b0, '0, '0);
        check("coll_clear", 64'(chk_busy2), 64'd0);

        // ---- x0 handling -----------------------------------------------
        drive1(1'b1, 5'd0, 32'h1234);
        settle();
        check_rdy("x0", 1'b0, 1'b1);
        tick();
        drive1(1'b0, '0, '0);
        check_wr("x0_wr", 1'b0, 5'd0, 32'h1234);
        sb_set_en = 1'b1; sb_set_addr = 5'd0; chk_addr1 = 5'd0;
        tick();
        sb_set_en = 1'b0;
        check("x0_busy", 64'(chk_busy1), 64'd0);

        // ---- Reset mid-operation ---------------------------------------
        sb_set_en = 1'b1; sb_set_addr = 5'd2; chk_addr1 = 5'd2;
        tick();
        sb_set_en = 1'b0;
        check("rst_pre_busy", 64'(chk_busy1), 64'd1);
        drive0(1'b1, 5'd2, 32'h22);
        drive1(1'b1, 5'd6, 32'h66);
        reset = 1'b1;
        settle();
        check_rdy("rst_ready", 1'b0, 1'b0);
        tick();
        check("rst_busy", 64'(chk_busy1), 64'd0);
        check_wr("rst_wr", 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        settle();
        // last_grant returns to its reset value: req0 wins the conflict.
        check_rdy("rst_after", 1'b1, 1'b0);
        tick();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        check_wr("rst_after_wr", 1'b1, 5'd2, 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
